// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the iterative AES-128 decryptor.
//   Contents:
//     SBOX / INV_SBOX       forward and inverse byte substitution tables
//     xtime, gmul           GF(2^8) arithmetic, reduction polynomial 0x11B
//     sub_word, rot_word    key-schedule word helpers
//     inv_shift_rows        state permutation (column-major, bit 127 = byte 0)
//     inv_mix_columns       column mix with coefficients {0e,0b,0d,09}
//     state_t               controller states IDLE / EXPAND / ROUNDS
//     NR, RCON_LAST         round count and the round constant of round 10
//   Optional build macro used by the top: AES_DEC_KEY_CACHE_EN.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int        NR        = 10;
    localparam logic [7:0] RCON_LAST = 8'h36;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ROUNDS
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte n sits at bits [127-8n -: 8]; n = 4*column + row.
    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c      -: 8];
            a1 = s[127 - 32 * c - 8  -: 8];
            a2 = s[127 - 32 * c - 16 -: 8];
            a3 = s[127 - 32 * c - 24 -: 8];
            o[127 - 32 * c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[127 - 32 * c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[127 - 32 * c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[127 - 32 * c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
//   Combinational single AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped
//   when last = 1, i.e. round 0).
//   Ports:
//     state_in   in  128  state entering the round
//     round_key  in  128  round key for this round
//     last       in  1    final round: no InvMixColumns
//     state_out  out 128  state leaving the round
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;

    always_comb begin
        // NOTE: every always_comb output gets a value before any branch or loop, so no latch is inferred.
        subbed  = '0;
        shifted = inv_shift_rows(state_in);
        for (int i = 0; i < 16; i++) begin
            subbed[127 - 8 * i -: 8] = INV_SBOX[shifted[127 - 8 * i -: 8]];
        end
        keyed     = subbed ^ round_key;
        state_out = last ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes128_decrypt.sv
// ---------------------------------------------------------------------------
// aes128_decrypt
//   Iterative AES-128 block decryptor. One forward key-schedule step or one
//   inverse round per clock; round keys are walked backwards from round key
//   10 on the fly, so no key table is stored.
//   Ports:
//     clk         in   1    rising-edge clock
//     rst         in   1    synchronous active-high reset (aborts a job)
//     in_valid    in   1    key/ciphertext present
//     in_ready    out  1    high in IDLE; accept = in_valid & in_ready
//     key         in   128  cipher key, bit 127 = byte 0
//     ciphertext  in   128  input block, bit 127 = byte 0
//     out_valid   out  1    one-cycle pulse with each result
//     plaintext   out  128  result, held until the next result
//   Latency accept edge -> out_valid: 21 cycles (10 expand, 1 initial
//   AddRoundKey, 10 inverse rounds).
//   Build option AES_DEC_KEY_CACHE_EN: keep the last round key 10 with its
//   source key; a matching key skips EXPAND (latency 11).
// ---------------------------------------------------------------------------
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         out_valid,
    output logic [127:0] plaintext
);

    localparam logic [3:0] LAST_CNT = 4'(NR);

    state_t       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         out_valid_d;
    logic [127:0] plaintext_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  v0, v1, v2, v3;
    logic [127:0] rk_fwd;
    logic [127:0] rk_rev;
    logic [7:0]   rcon_prev;
    logic [127:0] round_out;
    logic         last_round;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_q, key_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_rk_q, cache_rk_d;
    logic         cache_vld_q, cache_vld_d;
    logic         cache_hit;

    assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

    // Round-key words, w0 = most significant.
    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    // Forward schedule step: rk_(i) -> rk_(i+1) using rcon_q.
    assign f0     = w0 ^ sub_word(rot_word(w3)) ^ {rcon_q, 24'h0};
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};

    // Reverse schedule step: rk_(r+1) -> rk_r; rcon_q is the constant that
    // produced rk_(r+1).
    assign v3     = w3 ^ w2;
    assign v2     = w2 ^ w1;
    assign v1     = w1 ^ w0;
    assign v0     = w0 ^ sub_word(rot_word(v3)) ^ {rcon_q, 24'h0};
    assign rk_rev = {v0, v1, v2, v3};

    // Inverse of xtime over the rcon sequence (0x1B came from 0x80).
    assign rcon_prev = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};

    // In ROUNDS, cnt 0 is the initial AddRoundKey; cnt 1..10 are rounds 9..0.
    assign last_round = (cnt_q == LAST_CNT);

    aes_inv_round u_inv_round (
        .state_in  (blk_q),
        .round_key (rk_rev),
        .last      (last_round),
        .state_out (round_out)
    );

    assign in_ready = (fsm_q == IDLE);

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        rk_d        = rk_q;
        rcon_d      = rcon_q;
        out_valid_d = 1'b0;
        plaintext_d = plaintext;
`ifdef AES_DEC_KEY_CACHE_EN
        key_d       = key_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d  = ciphertext;
                    rk_d   = key;
                    rcon_d = 8'h01;
                    cnt_d  = 4'd0;
                    fsm_d  = EXPAND;
`ifdef AES_DEC_KEY_CACHE_EN
                    key_d = key;
                    if (cache_hit) begin
                        rk_d   = cache_rk_q;
                        rcon_d = RCON_LAST;
                        fsm_d  = ROUNDS;
                    end
`endif
                end
            end
            EXPAND: begin
                rk_d = rk_fwd;
                if (cnt_q == LAST_CNT - 4'd1) begin
                    // rcon stays at the constant of round 10 for the reverse walk.
                    cnt_d = 4'd0;
                    fsm_d = ROUNDS;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_key_d = key_q;
                    cache_rk_d  = rk_fwd;
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    rcon_d = xtime(rcon_q);
                end
            end
            ROUNDS: begin
                if (cnt_q == 4'd0) begin
                    blk_d = blk_q ^ rk_q;
                    cnt_d = 4'd1;
                end else begin
                    blk_d  = round_out;
                    rk_d   = rk_rev;
                    rcon_d = rcon_prev;
                    cnt_d  = cnt_q + 4'd1;
                    if (last_round) begin
                        plaintext_d = round_out;
                        out_valid_d = 1'b1;
                        cnt_d       = 4'd0;
                        fsm_d       = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: there are no arrays here, so every register, datapath included, is cleared; an aborted job leaves nothing behind.
            fsm_q       <= IDLE;
            cnt_q       <= 4'd0;
            blk_q       <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h00;
            out_valid   <= 1'b0;
            plaintext   <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            key_q       <= '0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            rcon_q      <= rcon_d;
            out_valid   <= out_valid_d;
            plaintext   <= plaintext_d;
`ifdef AES_DEC_KEY_CACHE_EN
            key_q       <= key_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes128_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes128_decrypt
//   Directed-vector bench for aes128_decrypt. Inputs change and outputs are
//   sampled 1 time unit after each rising edge.
//   Honours AES_DEC_KEY_CACHE_EN for the expected cached-key latency.
// ---------------------------------------------------------------------------
module tb_aes128_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic [127:0] plaintext;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;

    localparam int FULL_LAT = 21;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int CACHED_LAT = 11;
`else
    localparam int CACHED_LAT = 21;
`endif
    localparam int MAX_WAIT = 60;

    always #5 clk = ~clk;

    aes128_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .plaintext  (plaintext)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; lat counts cycles after the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
    endtask

    // Single job: accept, wait, check latency, result and pulse width.
    task automatic run_job(input string tag, input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int exp_lat);
        int lat;
        check({tag, "_ready"}, 128'(in_ready), 128'(1));
        key        = k;
        ciphertext = ct;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        wait_result(lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_pt"}, plaintext, exp_pt);
        tick();
        check({tag, "_pulse"}, 128'(out_valid), 128'(0));
        check({tag, "_hold"}, plaintext, exp_pt);
    endtask

    initial begin
        int lat;
        int stable_bad;
        int late_pulses;

        rst        = 1'b1;
        in_valid   = 1'b0;
        key        = '0;
        ciphertext = '0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 128'(in_ready), 128'(1));
        check("rst_ovalid", 128'(out_valid), 128'(0));
        check("rst_pt", plaintext, 128'h0);

        // Tests 1 and 2: reference vectors.
        run_job("t1", KEY1, CT1, PT1, FULL_LAT);
        run_job("t2", KEY2, CT2, PT2, FULL_LAT);

        // Test 3: back-to-back with in_valid held; second accept happens in
        // the first out_valid cycle, so the pulses are FULL_LAT+1 apart.
        key        = KEY1;
        ciphertext = CT1;
        in_valid   = 1'b1;
        tick();
        key        = KEY2;
        ciphertext = CT2;
        wait_result(lat);
        check("t3_lat1", 128'(lat), 128'(FULL_LAT));
        check("t3_pt1", plaintext, PT1);
        check("t3_ready_on_ovalid", 128'(in_ready), 128'(1));
        tick();
        in_valid   = 1'b0;
        lat        = 1;
        stable_bad = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            if (plaintext !== PT1) stable_bad++;
            tick();
            lat++;
        end
        check("t3_spacing", 128'(lat), 128'(FULL_LAT + 1));
        check("t3_pt_stable", 128'(stable_bad), 128'(0));
        check("t3_pt2", plaintext, PT2);
        tick();
        check("t3_pulse", 128'(out_valid), 128'(0));

        // Test 6: same key as the last expansion, then a new key.
        run_job("t6_same", KEY2, CT2, PT2, CACHED_LAT);
        run_job("t6_new", KEY1, CT1, PT1, FULL_LAT);

        // Test 4: request while busy is ignored.
        key        = KEY2;
        ciphertext = CT2;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t4_busy_ready", 128'(in_ready), 128'(0));
        key        = KEY1;
        ciphertext = CT1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 3;
        while (!out_valid && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check("t4_lat", 128'(lat), 128'(FULL_LAT));
        check("t4_pt", plaintext, PT2);
        tick();
        tick();
        check("t4_no_second", 128'(out_valid), 128'(0));

        // Test 5: reset in cycle 8 of a job.
        key        = KEY1;
        ciphertext = CT1;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ready", 128'(in_ready), 128'(1));
        check("t5_ovalid", 128'(out_valid), 128'(0));
        check("t5_pt", plaintext, 128'h0);
        late_pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) late_pulses++;
            tick();
        end
        check("t5_no_late", 128'(late_pulses), 128'(0));

        // After reset any cached key is gone: full latency again.
        run_job("t5_post", KEY2, CT2, PT2, FULL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
